// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT datapath blocks.
//   BUT_STAGES       : register stages in the pipelined butterfly.
//   calc_prod_w()    : full-precision complex-product width, IN_W+TW_W+1.
//   calc_t_w()       : width of the twiddle product after rescaling, IN_W+2.
//   calc_sum_w()     : width of A +/- T before scaling, IN_W+3.
//   saturate()       : width-generic signed clamp. The caller passes its own
//                      output width and truncates the result to that width.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int BUT_STAGES = 3;

  function automatic int calc_prod_w(input int in_w, input int tw_w);
    return in_w + tw_w + 1;
  endfunction

  function automatic int calc_t_w(input int in_w);
    return in_w + 2;
  endfunction

  function automatic int calc_sum_w(input int in_w);
    return in_w + 3;
  endfunction

  // Clamp x to [-2^(out_w-1), 2^(out_w-1)-1]. clamped reports whether the
  // value had to be limited.
  function automatic logic signed [63:0] saturate(input  logic signed [63:0] x,
                                                  input  int                 out_w,
                                                  output logic               clamped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    clamped = 1'b0;
    if (x > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (x < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// -----------------------------------------------------------------------------
// cmul_pipe
// Two-stage pipelined complex multiplier T = B * W, with W in Q1.(TW_W-1).
// Stage 1 captures the operands, stage 2 holds the rescaled product. Each
// stage carries a valid bit and an opaque side-band word (data that must
// stay aligned with the product, e.g. the butterfly's A operand).
// All stages advance together when en_i is high; bubbles are kept.
//
// Configuration macro: BUT_ROUND_EN -- round half up before the product
// rescale; otherwise the rescale truncates (floor).
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   en_i              : global pipeline advance
//   valid_i           : a beat is present on the operand inputs
//   b_r_i, b_i_i      : operand B (signed, IN_W)
//   w_r_i, w_i_i      : twiddle W (signed, TW_W)
//   side_i / side_o   : side-band word travelling with the beat
//   valid_o           : stage-2 valid
//   t_r_o, t_i_o      : rescaled product (signed, IN_W+2)
// -----------------------------------------------------------------------------
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int TW_W   = 8,
  parameter int SIDE_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic signed [IN_W-1:0] b_r_i,
  input  logic signed [IN_W-1:0] b_i_i,
  input  logic signed [TW_W-1:0] w_r_i,
  input  logic signed [TW_W-1:0] w_i_i,
  input  logic [SIDE_W-1:0]      side_i,
  output logic                   valid_o,
  output logic signed [IN_W+1:0] t_r_o,
  output logic signed [IN_W+1:0] t_i_o,
  output logic [SIDE_W-1:0]      side_o
);

  localparam int PROD_W = calc_prod_w(IN_W, TW_W);
  localparam int T_W    = calc_t_w(IN_W);

`ifdef BUT_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND_K = PROD_W'(1) <<< (TW_W - 2);
`else
  localparam logic signed [PROD_W-1:0] RND_K = '0;
`endif

  // Stage 1: operand capture
  logic                   v1_q;
  logic signed [IN_W-1:0] b_r_q, b_i_q;
  logic signed [TW_W-1:0] w_r_q, w_i_q;
  logic [SIDE_W-1:0]      side1_q;

  // Stage 2: rescaled product
  logic                   v2_q;
  logic signed [T_W-1:0]  t_r_q, t_i_q;
  logic [SIDE_W-1:0]      side2_q;

  logic signed [PROD_W-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PROD_W-1:0] prod_r, prod_i;
  logic signed [T_W-1:0]    t_r_d, t_i_d;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here unconditionally), so no latch can be inferred.
  always_comb begin
    br_x   = PROD_W'(b_r_q);
    bi_x   = PROD_W'(b_i_q);
    wr_x   = PROD_W'(w_r_q);
    wi_x   = PROD_W'(w_i_q);
    prod_r = br_x * wr_x - bi_x * wi_x + RND_K;
    prod_i = br_x * wi_x + bi_x * wr_x + RND_K;
    // Dropping TW_W-1 fraction bits leaves IN_W+2 bits; the extra top bit is
    // only reached by the -1 twiddle corners.
    t_r_d  = T_W'(prod_r >>> (TW_W - 1));
    t_i_d  = T_W'(prod_i >>> (TW_W - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well as valids so the visible
      // outputs come up at a defined zero rather than X.
      v1_q    <= 1'b0;
      b_r_q   <= '0;
      b_i_q   <= '0;
      w_r_q   <= '0;
      w_i_q   <= '0;
      side1_q <= '0;
      v2_q    <= 1'b0;
      t_r_q   <= '0;
      t_i_q   <= '0;
      side2_q <= '0;
    end else if (en_i) begin
      v1_q <= valid_i;
      if (valid_i) begin
        b_r_q   <= b_r_i;
        b_i_q   <= b_i_i;
        w_r_q   <= w_r_i;
        w_i_q   <= w_i_i;
        side1_q <= side_i;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        t_r_q   <= t_r_d;
        t_i_q   <= t_i_d;
        side2_q <= side1_q;
      end
    end
  end

  assign valid_o = v2_q;
  assign t_r_o   = t_r_q;
  assign t_i_o   = t_i_q;
  assign side_o  = side2_q;

endmodule

// File: rtl/but_pipe_complex.sv
// -----------------------------------------------------------------------------
// but_pipe_complex
// Pipelined radix-2 DIT complex butterfly: P = A + W*B, N = A - W*B.
// S1/S2 (operand capture, twiddle multiply) live in cmul_pipe; S3 here forms
// the sums, applies the optional divide-by-2, saturates to OUT_W and raises
// the sticky overflow flag. The whole pipe advances on en = !v3 || out_ready,
// so a stalled output freezes every stage and bubbles are never collapsed.
// Latency is three cycles; throughput is one beat per cycle.
//
// Configuration macro: BUT_ROUND_EN -- round half up at the product rescale
// and at the divide-by-2; otherwise both truncate. Saturation follows rounding.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (in_ready = pipeline enable)
//   in_a_r, in_a_i        : operand A (signed, IN_W)
//   in_b_r, in_b_i        : operand B (signed, IN_W)
//   in_w_r, in_w_i        : twiddle W (signed Q1.(TW_W-1))
//   in_scale              : 1 = halve the results of this beat
//   out_valid / out_ready : output handshake
//   out_p_r, out_p_i      : A + W*B (signed, OUT_W)
//   out_n_r, out_n_i      : A - W*B (signed, OUT_W)
//   ovf                   : sticky saturation flag
//   ovf_clr               : synchronous clear of ovf (a new set wins)
// OUT_W must lie in [2, IN_W+2].
// -----------------------------------------------------------------------------
module but_pipe_complex
  import fft_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int TW_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_a_r,
  input  logic signed [IN_W-1:0]  in_a_i,
  input  logic signed [IN_W-1:0]  in_b_r,
  input  logic signed [IN_W-1:0]  in_b_i,
  input  logic signed [TW_W-1:0]  in_w_r,
  input  logic signed [TW_W-1:0]  in_w_i,
  input  logic                    in_scale,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_p_r,
  output logic signed [OUT_W-1:0] out_p_i,
  output logic signed [OUT_W-1:0] out_n_r,
  output logic signed [OUT_W-1:0] out_n_i,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int T_W    = calc_t_w(IN_W);
  localparam int SUM_W  = calc_sum_w(IN_W);
  localparam int SIDE_W = 2 * IN_W + 1;

`ifdef BUT_ROUND_EN
  localparam logic signed [SUM_W-1:0] HALF_RND = SUM_W'(1);
`else
  localparam logic signed [SUM_W-1:0] HALF_RND = '0;
`endif

  // Result slots in the S3 arrays
  typedef enum logic [1:0] {
    RES_P_R = 2'd0,
    RES_P_I = 2'd1,
    RES_N_R = 2'd2,
    RES_N_I = 2'd3
  } res_idx_e;

  logic en;

  // S2 view from the multiplier
  logic                   v2;
  logic signed [T_W-1:0]  t_r, t_i;
  logic [SIDE_W-1:0]      side_s1, side_s2;
  logic                   s2_scale;
  logic signed [IN_W-1:0] s2_a_r, s2_a_i;

  // S3 combinational datapath
  logic signed [SUM_W-1:0] raw [4];
  logic signed [SUM_W-1:0] adj [4];
  logic signed [SUM_W-1:0] scl [4];
  logic signed [OUT_W-1:0] res_d [4];
  logic                    clamp [4];
  logic                    clamp_any;
  logic                    ovf_set;

  // S3 registers
  logic                    v3_q;
  logic signed [OUT_W-1:0] p_r_q, p_i_q, n_r_q, n_i_q;
  logic                    ovf_q;

  // Only a held, unaccepted S3 beat blocks the pipe.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  // A and the scale select ride alongside the product.
  assign side_s1 = {in_scale, in_a_r, in_a_i};
  assign {s2_scale, s2_a_r, s2_a_i} = side_s2;

  cmul_pipe #(
    .IN_W   (IN_W),
    .TW_W   (TW_W),
    .SIDE_W (SIDE_W)
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (in_valid),
    .b_r_i   (in_b_r),
    .b_i_i   (in_b_i),
    .w_r_i   (in_w_r),
    .w_i_i   (in_w_i),
    .side_i  (side_s1),
    .valid_o (v2),
    .t_r_o   (t_r),
    .t_i_o   (t_i),
    .side_o  (side_s2)
  );

  always_comb begin
    raw[RES_P_R] = SUM_W'(s2_a_r) + SUM_W'(t_r);
    raw[RES_P_I] = SUM_W'(s2_a_i) + SUM_W'(t_i);
    raw[RES_N_R] = SUM_W'(s2_a_r) - SUM_W'(t_r);
    raw[RES_N_I] = SUM_W'(s2_a_i) - SUM_W'(t_i);
    clamp_any    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      adj[k]   = raw[k] + (s2_scale ? HALF_RND : '0);
      scl[k]   = s2_scale ? (adj[k] >>> 1) : raw[k];
      res_d[k] = OUT_W'(saturate(64'(scl[k]), OUT_W, clamp[k]));
      clamp_any = clamp_any | clamp[k];
    end
  end

  // The flag is raised as the clamped beat lands in S3, so it is visible
  // together with that beat's out_valid.
  assign ovf_set = en && v2 && clamp_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q  <= 1'b0;
      p_r_q <= '0;
      p_i_q <= '0;
      n_r_q <= '0;
      n_i_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (en) begin
        v3_q <= v2;
        if (v2) begin
          p_r_q <= res_d[RES_P_R];
          p_i_q <= res_d[RES_P_I];
          n_r_q <= res_d[RES_N_R];
          n_i_q <= res_d[RES_N_I];
        end
      end
      // Set has priority over a coincident clear.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_p_r   = p_r_q;
  assign out_p_i   = p_i_q;
  assign out_n_r   = n_r_q;
  assign out_n_i   = n_i_q;
  assign ovf       = ovf_q;

endmodule
